uart_receive: RTL and testbench
===============================

// Module: uart_receive
// PURPOSE
//  UART 8N1 receiver peripheral; the receive counterpart of uart_transmit on the AXI4-Lite bus.
//  Oversamples serial rx, pushes good bytes into a small FIFO, exposes DATA/STATUS registers.
//  Sits behind an axi4_lite_slave port (addr/wdata/write/read/rdata), same as the TX peripheral.
// PARAMETERS
//  ADDR_WIDTH    32   peripheral address width
//  DATA_WIDTH    32   register width
//  CLKS_PER_BIT  434  clk cycles per bit (50 MHz / 115200); must be >= 4
//  FIFO_DEPTH    8    RX FIFO entries; power of 2, >= 2
// PORTS
//  clk     in   1           system clock, rising edge
//  rst     in   1           asynchronous reset, active-high
//  rx      in   1           serial input, asynchronous to clk, idle high
//  addr    in   ADDR_WIDTH  register address; only addr[3:2] decoded
//  wdata   in   DATA_WIDTH  write data
//  write   in   1           one-cycle write strobe
//  read    in   1           one-cycle read strobe (pops FIFO on DATA read)
//  rdata   out  DATA_WIDTH  combinational read data for current addr
//  rx_irq  out  1           high while FIFO not empty
// BEHAVIOUR
//  Registers: addr[3:2]=0 DATA  (RO): {24'b0, FIFO head}; 0 when empty.
//             addr[3:2]=1 STATUS: [0]=not_empty [1]=full [2]=frame_err [3]=overrun
//                         [7:4]=entry count (saturates at 15); bits [3:2] W1C; rest RO.
//             other offsets read 0; writes ignored.
//  Reset: FSM IDLE, FIFO empty, pointers/count 0, error flags 0, sync flops 1.
//    rdata=0 for all addr, rx_irq=0.
//  Sync: rx through 2 flops (reset to 1); all FSM decisions use synced rx.
//  FSM (bit counter 0..7, baud counter 0..CLKS_PER_BIT-1):
//    IDLE : synced rx==0 -> START, baud cnt cleared.
//    START: at cnt==CLKS_PER_BIT/2-1 sample; rx==1 -> IDLE (glitch, no flag);
//           rx==0 -> DATA, cnt cleared, bit=0.
//    DATA : at cnt==CLKS_PER_BIT-1 sample into shift reg LSB first; after bit 7 -> STOP.
//    STOP : at cnt==CLKS_PER_BIT-1 sample; 1 -> push byte; 0 -> frame_err=1, byte dropped.
//           Either way -> IDLE next cycle.
//  Frame error with rx held low: IDLE sees rx==0 and restarts; a break repeats frame_err.
//  Latency: byte visible (not_empty, rx_irq) 1 clk after the stop-bit sample edge.
//  Pop: read && addr[3:2]==0 && not_empty -> read pointer advances at the clk edge.
//    rdata during that cycle shows the old head.
//    Read of DATA when empty: no state change.
//  Full: push while full and no pop -> byte discarded, overrun=1, FIFO unchanged.
//  Simultaneous push+pop: pop first, push accepted, count unchanged, no overrun (also when full).
//  W1C: write && addr[3:2]==1 clears frame_err if wdata[2]=1, overrun if wdata[3]=1.
//    A same-cycle set wins over clear.
//  Pointers wrap modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1.
//  rst mid-frame: FSM to IDLE, partial byte lost, FIFO emptied, flags cleared.
//    No spurious push after release.
//    Receive resumes on the next falling edge.
// TESTING  (CLKS_PER_BIT=16, FIFO_DEPTH=8)
//  Send 0xA5 8N1 -> STATUS=0x11, rx_irq=1; DATA read returns 0x000000A5.
//    Then STATUS=0x00, rx_irq=0.
//  Send 9 bytes 0x01..0x09, no reads -> STATUS=0x8B (count 8, full, overrun).
//    DATA reads return 0x01..0x08; 0x09 lost.
//  Send 0x3C with stop bit 0 -> frame_err=1, FIFO empty.
//    Write STATUS wdata=0x4 -> STATUS=0x00.
//  rx low pulse of 4 clks -> no byte, no flag, FSM back in IDLE.
//  FIFO full, DATA read in the same cycle as the stop sample -> no overrun.
//    Count stays 8 and the new byte lands at the tail.
//  Assert rst at data bit 4 of 0x55, release, send 0x81.
//    FIFO holds only 0x81; STATUS=0x11.

Source files
------------

// File: rtl/uart_receive_if.sv
// Register-bus bundle for the UART receive peripheral: address, write data,
// one-cycle write/read strobes and combinational read data.
interface uart_receive_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  write;
  logic                  read;
  logic [DATA_WIDTH-1:0] rdata;

  modport slave  (input  addr, wdata, write, read, output rdata);
  modport master (output addr, wdata, write, read, input  rdata);
endinterface

// File: rtl/uart_receive.sv
// UART 8N1 receiver: synchronises rx, samples mid-bit, pushes good bytes into
// a small FIFO and exposes DATA/STATUS registers on the register bus.
module uart_receive #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  uart_receive_if.slave  bus,
  output logic           rx_irq
);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] HALF_M1 = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_M1 = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_rx_s1, r_rx_s2;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic              w_baud_clr, w_shift_en, w_push, w_frame_set;

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_frame_err, r_overrun;
  logic              w_sel_data, w_sel_stat, w_not_empty, w_full;
  logic              w_pop, w_push_ok, w_overrun_set;
  logic [3:0]        w_cnt_sat;
  logic              w_unused;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_state <= w_state_nxt;
      r_baud  <= w_baud_clr ? '0 : r_baud + BAUD_W'(1);
      if (r_state != S_DATA) r_bit <= '0;
      else if (w_shift_en)   r_bit <= r_bit + 3'd1;
      if (w_shift_en) r_shift <= {r_rx_s2, r_shift[7:1]};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_clr  = 1'b0;
    w_shift_en  = 1'b0;
    w_push      = 1'b0;
    w_frame_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_clr = 1'b1;
        if (!r_rx_s2) w_state_nxt = S_START;
      end
      S_START: if (r_baud == HALF_M1) begin
        w_baud_clr  = 1'b1;
        w_state_nxt = r_rx_s2 ? S_IDLE : S_DATA;
      end
      S_DATA: if (r_baud == FULL_M1) begin
        w_baud_clr = 1'b1;
        w_shift_en = 1'b1;
        if (r_bit == 3'd7) w_state_nxt = S_STOP;
      end
      S_STOP: if (r_baud == FULL_M1) begin
        w_baud_clr  = 1'b1;
        w_state_nxt = S_IDLE;
        if (r_rx_s2) w_push = 1'b1;
        else         w_frame_set = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_sel_data  = (bus.addr[3:2] == 2'd0);
  assign w_sel_stat  = (bus.addr[3:2] == 2'd1);
  assign w_not_empty = (r_count != '0);
  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop       = bus.read & w_sel_data & w_not_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_push_ok     = w_push & (~w_full | w_pop);
  assign w_overrun_set = w_push & w_full & ~w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)     r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_frame_set)                               r_frame_err <= 1'b1;
      else if (bus.write && w_sel_stat && bus.wdata[2]) r_frame_err <= 1'b0;
      if (w_overrun_set)                             r_overrun <= 1'b1;
      else if (bus.write && w_sel_stat && bus.wdata[3]) r_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= r_shift;
  end

  assign w_cnt_sat = (r_count > CNT_W'(15)) ? 4'hF : 4'(r_count);

  always_comb begin
    bus.rdata = '0;
    if (w_sel_data && w_not_empty)
      bus.rdata = DATA_WIDTH'(r_mem[r_rptr]);
    else if (w_sel_stat)
      bus.rdata = DATA_WIDTH'({w_cnt_sat, r_overrun, r_frame_err, w_full, w_not_empty});
  end

  assign rx_irq   = w_not_empty;
  assign w_unused = ^{bus.addr, bus.wdata};
endmodule

// File: tb/tb_uart_receive.sv
// Directed bench for uart_receive with 16 clocks per bit and an 8-entry FIFO.
module tb_uart_receive;
  localparam int unsigned CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic rx_irq;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] rd;

  uart_receive_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

  uart_receive #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .bus(bus_if), .rx_irq(rx_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All bus/serial tasks start and end on a falling clock edge.
  task automatic reg_read(input logic [31:0] a, output logic [31:0] d);
    bus_if.addr = a;
    bus_if.read = 1'b1;
    #1 d = bus_if.rdata;
    @(negedge clk);
    bus_if.read = 1'b0;
  endtask

  task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
    bus_if.addr  = a;
    bus_if.wdata = d;
    bus_if.write = 1'b1;
    @(negedge clk);
    bus_if.write = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.addr  = '0;
    bus_if.wdata = '0;
    bus_if.write = 1'b0;
    bus_if.read  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    reg_read(32'h0, rd); check("rst_data", rd, 32'h0);
    reg_read(32'h4, rd); check("rst_status", rd, 32'h0);
    reg_read(32'h8, rd); check("rst_off8", rd, 32'h0);
    reg_read(32'hC, rd); check("rst_offC", rd, 32'h0);
    check("rst_irq", 32'(rx_irq), 32'h0);

    // Single byte
    send_byte(8'hA5, 1'b1);
    reg_read(32'h4, rd); check("a5_status", rd, 32'h11);
    check("a5_irq", 32'(rx_irq), 32'h1);
    reg_read(32'h0, rd); check("a5_data", rd, 32'h0000_00A5);
    reg_read(32'h4, rd); check("a5_status_after", rd, 32'h0);
    check("a5_irq_after", 32'(rx_irq), 32'h0);

    // Overfill: ninth byte is lost
    for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1);
    reg_read(32'h4, rd); check("ovf_status", rd, 32'h8B);
    for (int i = 1; i <= 8; i++) begin
      reg_read(32'h0, rd); check("ovf_data", rd, 32'(i));
    end
    reg_read(32'h4, rd); check("ovf_status_drained", rd, 32'h08);
    reg_write(32'h4, 32'h8);
    reg_read(32'h4, rd); check("ovf_w1c", rd, 32'h0);

    // Frame error
    send_byte(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    reg_read(32'h4, rd); check("ferr_status", rd, 32'h04);
    reg_write(32'h4, 32'h4);
    reg_read(32'h4, rd); check("ferr_w1c", rd, 32'h0);

    // Short low glitch, then a normal byte must still decode
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    reg_read(32'h4, rd); check("glitch_status", rd, 32'h0);
    send_byte(8'h5A, 1'b1);
    reg_read(32'h0, rd); check("glitch_next_data", rd, 32'h5A);

    // Full FIFO with a pop coinciding with the stop-bit sample
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b1);
    reg_read(32'h4, rd); check("full_status", rd, 32'h83);
    fork
      send_byte(8'h99, 1'b1);
      begin
        repeat (154) @(negedge clk);
        bus_if.addr = 32'h0;
        bus_if.read = 1'b1;
        #1 check("full_pop_head", bus_if.rdata, 32'h10);
        @(negedge clk);
        bus_if.read = 1'b0;
      end
    join
    reg_read(32'h4, rd); check("full_pop_status", rd, 32'h83);
    for (int i = 1; i < 8; i++) begin
      reg_read(32'h0, rd); check("full_data", rd, 32'h10 + 32'(i));
    end
    reg_read(32'h0, rd); check("full_tail", rd, 32'h99);
    reg_read(32'h4, rd); check("full_empty_status", rd, 32'h0);

    // Reset during data bit 4 of 0x55, with a byte already queued
    send_byte(8'h77, 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = ((i % 2) == 0);
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    reg_read(32'h4, rd); check("rst_mid_status", rd, 32'h0);
    check("rst_mid_irq", 32'(rx_irq), 32'h0);
    send_byte(8'h81, 1'b1);
    reg_read(32'h4, rd); check("post_rst_status", rd, 32'h11);
    reg_read(32'h0, rd); check("post_rst_data", rd, 32'h81);
    reg_read(32'h4, rd); check("post_rst_empty", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
